// File: rtl/read_training_delay_ctrl_if.sv
// Lane-side control/status bundle between the read-training controller,
// the IOD delay line / eye monitor and the PHY training sequencer.
interface read_training_delay_ctrl_if;
  // sequencer -> controller
  logic       START;
  // IOD -> controller
  logic       EYE_MONITOR_EARLY;
  logic       EYE_MONITOR_LATE;
  logic       DELAY_LINE_OUT_OF_RANGE;
  // controller -> IOD
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  // controller -> sequencer
  logic       BUSY;
  logic       DONE;
  logic       ERROR;
  logic [7:0] CENTER_TAP;
  logic [7:0] WINDOW_WIDTH;

  // controller side
  modport master (
    input  START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, ERROR, CENTER_TAP, WINDOW_WIDTH
  );

  // IOD / sequencer side
  modport slave (
    output START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
           EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, ERROR, CENTER_TAP, WINDOW_WIDTH
  );
endinterface

// File: rtl/read_training_delay_ctrl.sv
// Per-lane DQ read-training controller. Sweeps the input delay line upward
// from tap 0, finds the first passing window in the eye monitor flags and
// walks back to the window centre. All outputs come straight from flops.
module read_training_delay_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MAX_TAPS      = 127,
  parameter int MIN_WINDOW    = 4
) (
  input  logic                          FAB_CLK,
  input  logic                          ARST,
  read_training_delay_ctrl_if.master    bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] MAX_TAP     = 8'(MAX_TAPS);
  localparam logic [7:0] MIN_WIN     = 8'(MIN_WINDOW);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CENTER,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tap_q, tap_d;
  logic [7:0] left_q, left_d;
  logic [7:0] right_q, right_d;
  logic       in_window_q, in_window_d;
  logic       fail_q, fail_d;
  logic       oor_q, oor_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] target_q, target_d;
  logic [7:0] width_q, width_d;

  logic       load_q, load_d;
  logic       move_q, move_d;
  logic       dir_q, dir_d;
  logic       clr_q, clr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [7:0] center_tap_q, center_tap_d;
  logic [7:0] window_width_q, window_width_d;

  // EVAL scratch values
  logic       scan_end;
  logic       have_win;
  logic [7:0] left_c, right_c, width_c, target_c, moves_c;

  // Next-state and next-output logic for the training sequence
  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    left_d         = left_q;
    right_d        = right_q;
    in_window_d    = in_window_q;
    fail_d         = fail_q;
    oor_d          = oor_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    width_d        = width_q;
    load_d         = 1'b0;
    move_d         = 1'b0;
    dir_d          = dir_q;
    clr_d          = 1'b0;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
    center_tap_d   = center_tap_q;
    window_width_d = window_width_q;
    scan_end       = 1'b0;
    have_win       = 1'b0;
    left_c         = left_q;
    right_c        = right_q;
    width_c        = 8'd0;
    target_c       = 8'd0;
    moves_c        = 8'd0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // results hold here until the sequencer asks again
        if (bus.START) begin
          state_d        = ST_LOAD;
          load_d         = 1'b1;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          center_tap_d   = 8'd0;
          window_width_d = 8'd0;
          tap_d          = 8'd0;
          left_d         = 8'd0;
          right_d        = 8'd0;
          in_window_d    = 1'b0;
        end
      end

      ST_LOAD: begin
        state_d = ST_CLEAR;
        clr_d   = 1'b1;
      end

      ST_CLEAR: begin
        fail_d  = 1'b0;
        oor_d   = 1'b0;
        cnt_d   = SETTLE_LAST;
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = SAMPLE_LAST;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_SAMPLE: begin
        fail_d = fail_q | bus.EYE_MONITOR_EARLY | bus.EYE_MONITOR_LATE
                        | bus.DELAY_LINE_OUT_OF_RANGE;
        oor_d  = oor_q | bus.DELAY_LINE_OUT_OF_RANGE;
        if (cnt_q == 8'd0) state_d = ST_EVAL;
        else               cnt_d   = cnt_q - 8'd1;
      end

      ST_EVAL: begin
        // Only the first window is ever considered; once it closes the scan ends.
        if (oor_q) begin
          scan_end = 1'b1;
          have_win = in_window_q;
          right_c  = tap_q - 8'd1;
        end else if (!fail_q && !in_window_q) begin
          left_c      = tap_q;
          in_window_d = 1'b1;
          if (tap_q == MAX_TAP) begin
            scan_end = 1'b1;
            have_win = 1'b1;
            right_c  = tap_q;
          end
        end else if (fail_q && in_window_q) begin
          scan_end = 1'b1;
          have_win = 1'b1;
          right_c  = tap_q - 8'd1;
        end else if (tap_q == MAX_TAP) begin
          scan_end = 1'b1;
          have_win = in_window_q;
          right_c  = tap_q;
        end
        left_d   = left_c;
        right_d  = right_c;
        width_c  = right_c - left_c + 8'd1;
        target_c = left_c + ((right_c - left_c) >> 1);
        moves_c  = tap_q - target_c;

        if (!scan_end) begin
          state_d = ST_STEP;
          move_d  = 1'b1;
          dir_d   = 1'b1;
        end else if (!have_win || (width_c < MIN_WIN)) begin
          state_d        = ST_DONE;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          error_d        = 1'b1;
          window_width_d = have_win ? width_c : 8'd0;
        end else if (moves_c == 8'd0) begin
          // already sitting on the centre tap
          state_d        = ST_DONE;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          center_tap_d   = target_c;
          window_width_d = width_c;
        end else begin
          state_d  = ST_CENTER;
          move_d   = 1'b1;
          dir_d    = 1'b0;
          cnt_d    = moves_c - 8'd1;
          target_d = target_c;
          width_d  = width_c;
        end
      end

      ST_STEP: begin
        tap_d   = tap_q + 8'd1;
        clr_d   = 1'b1;
        state_d = ST_CLEAR;
      end

      ST_CENTER: begin
        // MOVE alternates high/low; cnt_q counts pulses still to issue
        if (move_q) begin
          tap_d = tap_q - 8'd1;
        end else if (cnt_q != 8'd0) begin
          move_d = 1'b1;
          cnt_d  = cnt_q - 8'd1;
        end else begin
          state_d        = ST_DONE;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          center_tap_d   = target_q;
          window_width_d = width_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops every output immediately
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q        <= ST_IDLE;
      tap_q          <= 8'd0;
      left_q         <= 8'd0;
      right_q        <= 8'd0;
      in_window_q    <= 1'b0;
      fail_q         <= 1'b0;
      oor_q          <= 1'b0;
      cnt_q          <= 8'd0;
      target_q       <= 8'd0;
      width_q        <= 8'd0;
      load_q         <= 1'b0;
      move_q         <= 1'b0;
      dir_q          <= 1'b0;
      clr_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      center_tap_q   <= 8'd0;
      window_width_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      left_q         <= left_d;
      right_q        <= right_d;
      in_window_q    <= in_window_d;
      fail_q         <= fail_d;
      oor_q          <= oor_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      width_q        <= width_d;
      load_q         <= load_d;
      move_q         <= move_d;
      dir_q          <= dir_d;
      clr_q          <= clr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      center_tap_q   <= center_tap_d;
      window_width_q <= window_width_d;
    end
  end

  assign bus.DELAY_LINE_LOAD         = load_q;
  assign bus.DELAY_LINE_MOVE         = move_q;
  assign bus.DELAY_LINE_DIRECTION    = dir_q;
  assign bus.EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign bus.BUSY                    = busy_q;
  assign bus.DONE                    = done_q;
  assign bus.ERROR                   = error_q;
  assign bus.CENTER_TAP              = center_tap_q;
  assign bus.WINDOW_WIDTH            = window_width_q;

endmodule

// File: tb/tb_read_training_delay_ctrl.sv
// Directed bench for read_training_delay_ctrl: a small IOD model tracks the
// delay-line tap from LOAD/MOVE pulses and produces eye flags per scenario.
module tb_read_training_delay_ctrl;

  logic clk  = 1'b0;
  logic arst = 1'b0;

  read_training_delay_ctrl_if bus_if ();

  read_training_delay_ctrl dut (
    .FAB_CLK (clk),
    .ARST    (arst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         mode     = 7;   // eye scenario; 7 = quiet
  int         cyc      = 0;
  int         dec_cnt  = 0;
  int         dbl_cnt  = 0;
  logic [7:0] mtap     = 8'd0;
  logic       prev_move = 1'b0;
  int         start_cyc = 0;
  int         dec_base  = 0;

  // Eye scenarios:
  // 0: pass 10..30   1: never passes   2: pass 5..6
  // 3: pass from 20, out of range from 40   4: pass from 100
  assign bus_if.EYE_MONITOR_EARLY = (mode == 0 && mtap < 8'd10) || (mode == 1) ||
                                    (mode == 2 && mtap < 8'd5)  || (mode == 3 && mtap < 8'd20) ||
                                    (mode == 4 && mtap < 8'd100);
  assign bus_if.EYE_MONITOR_LATE  = (mode == 0 && mtap > 8'd30) || (mode == 2 && mtap > 8'd6);
  assign bus_if.DELAY_LINE_OUT_OF_RANGE = (mode == 3 && mtap >= 8'd40);

  // Delay line model and pulse bookkeeping
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.DELAY_LINE_LOAD)      mtap <= 8'd0;
    else if (bus_if.DELAY_LINE_MOVE) mtap <= bus_if.DELAY_LINE_DIRECTION ? mtap + 8'd1 : mtap - 8'd1;
    if (bus_if.DELAY_LINE_MOVE && !bus_if.DELAY_LINE_DIRECTION) dec_cnt <= dec_cnt + 1;
    if (bus_if.DELAY_LINE_MOVE && prev_move) dbl_cnt <= dbl_cnt + 1;
    prev_move <= bus_if.DELAY_LINE_MOVE;
  end

  task automatic do_start(input int hold);
    @(negedge clk);
    bus_if.START = 1'b1;
    start_cyc = cyc;
    dec_base  = dec_cnt;
    repeat (hold) @(negedge clk);
    bus_if.START = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit to, output int dcyc, output bit pbusy);
    to = 1'b1; dcyc = 0; pbusy = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus_if.DONE) begin
        to = 1'b0;
        dcyc = cyc - start_cyc;
        break;
      end
      pbusy = bus_if.BUSY;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus_if.START = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_if.DELAY_LINE_LOAD, bus_if.DELAY_LINE_MOVE, bus_if.DELAY_LINE_DIRECTION,
         bus_if.EYE_MONITOR_CLEAR_FLAGS, bus_if.BUSY, bus_if.DONE, bus_if.ERROR,
         bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b ctap=%0d width=%0d, expected all 0",
               bus_if.BUSY, bus_if.DONE, bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH);
    end
    arst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_centered_eye();
    bit to, pb; int dc;
    mode = 0;
    do_start(1);
    n_checks++;
    if (bus_if.DELAY_LINE_LOAD !== 1'b1 || cyc - start_cyc != 1 || bus_if.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL load_timing: load=%b busy=%b at cycle %0d, expected 1/1 at cycle 1",
                         bus_if.DELAY_LINE_LOAD, bus_if.BUSY, cyc - start_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.EYE_MONITOR_CLEAR_FLAGS !== 1'b1 || bus_if.DELAY_LINE_LOAD !== 1'b0) begin
      n_fail++; $display("FAIL clear_timing: clear=%b load=%b, expected 1/0",
                         bus_if.EYE_MONITOR_CLEAR_FLAGS, bus_if.DELAY_LINE_LOAD);
    end
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL centered_timeout: DONE not seen, expected DONE"); end
    n_checks++;
    if (dc != 887 || pb !== 1'b1 || bus_if.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL centered_done_cycle: cycle %0d busy_before=%b busy=%b, expected 887/1/0",
                         dc, pb, bus_if.BUSY);
    end
    n_checks++;
    if (bus_if.ERROR !== 1'b0 || bus_if.CENTER_TAP !== 8'd20 || bus_if.WINDOW_WIDTH !== 8'd21) begin
      n_fail++; $display("FAIL centered_result: err=%b ctap=%0d width=%0d, expected 0/20/21",
                         bus_if.ERROR, bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH);
    end
    n_checks++;
    if (dec_cnt - dec_base != 11 || mtap !== 8'd20 || dbl_cnt != 0) begin
      n_fail++; $display("FAIL centered_moves: dec=%0d tap=%0d dbl=%0d, expected 11/20/0",
                         dec_cnt - dec_base, mtap, dbl_cnt);
    end
  endtask

  task automatic test_no_eye();
    bit to, pb; int dc;
    mode = 1;
    do_start(1);
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL no_eye_timeout: DONE not seen, expected DONE"); end
    n_checks++;
    if (bus_if.ERROR !== 1'b1 || bus_if.WINDOW_WIDTH !== 8'd0 || bus_if.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL no_eye_result: err=%b width=%0d busy=%b, expected 1/0/0",
                         bus_if.ERROR, bus_if.WINDOW_WIDTH, bus_if.BUSY);
    end
    n_checks++;
    if (dec_cnt - dec_base != 0 || mtap !== 8'd127) begin
      n_fail++; $display("FAIL no_eye_sweep: dec=%0d tap=%0d, expected 0/127", dec_cnt - dec_base, mtap);
    end
  endtask

  task automatic test_narrow_window();
    bit to, pb; int dc;
    mode = 2;
    do_start(1);
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to || bus_if.ERROR !== 1'b1 || bus_if.WINDOW_WIDTH !== 8'd2) begin
      n_fail++; $display("FAIL narrow_result: timeout=%b err=%b width=%0d, expected 0/1/2",
                         to, bus_if.ERROR, bus_if.WINDOW_WIDTH);
    end
    n_checks++;
    if (dec_cnt - dec_base != 0 || mtap !== 8'd7) begin
      n_fail++; $display("FAIL narrow_sweep: dec=%0d tap=%0d, expected 0/7", dec_cnt - dec_base, mtap);
    end
  endtask

  task automatic test_out_of_range();
    bit to, pb; int dc;
    mode = 3;
    do_start(1);
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to || bus_if.ERROR !== 1'b0 || bus_if.CENTER_TAP !== 8'd29 || bus_if.WINDOW_WIDTH !== 8'd20) begin
      n_fail++; $display("FAIL oor_result: timeout=%b err=%b ctap=%0d width=%0d, expected 0/0/29/20",
                         to, bus_if.ERROR, bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH);
    end
    n_checks++;
    if (dec_cnt - dec_base != 11 || mtap !== 8'd29) begin
      n_fail++; $display("FAIL oor_moves: dec=%0d tap=%0d, expected 11/29", dec_cnt - dec_base, mtap);
    end
  endtask

  // START held high in DONE restarts right away; extra START while busy is ignored
  task automatic test_back_to_back();
    bit to, pb; int dc;
    do_start(1);
    n_checks++;
    if (bus_if.DELAY_LINE_LOAD !== 1'b1 || bus_if.DONE !== 1'b0 || bus_if.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart: load=%b done=%b busy=%b, expected 1/0/1",
                         bus_if.DELAY_LINE_LOAD, bus_if.DONE, bus_if.BUSY);
    end
    bus_if.START = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.START = 1'b0;
    n_checks++;
    if (bus_if.DELAY_LINE_LOAD !== 1'b0 || mtap !== 8'd0) begin
      n_fail++; $display("FAIL b2b_ignore_start: load=%b tap=%0d, expected 0/0", bus_if.DELAY_LINE_LOAD, mtap);
    end
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to || bus_if.CENTER_TAP !== 8'd29 || bus_if.WINDOW_WIDTH !== 8'd20 || dec_cnt - dec_base != 11) begin
      n_fail++; $display("FAIL b2b_result: timeout=%b ctap=%0d width=%0d dec=%0d, expected 0/29/20/11",
                         to, bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH, dec_cnt - dec_base);
    end
  endtask

  task automatic test_top_window();
    bit to, pb; int dc;
    mode = 4;
    do_start(1);
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to || bus_if.ERROR !== 1'b0 || bus_if.CENTER_TAP !== 8'd113 || bus_if.WINDOW_WIDTH !== 8'd28) begin
      n_fail++; $display("FAIL top_result: timeout=%b err=%b ctap=%0d width=%0d, expected 0/0/113/28",
                         to, bus_if.ERROR, bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH);
    end
    n_checks++;
    if (dec_cnt - dec_base != 14 || mtap !== 8'd113) begin
      n_fail++; $display("FAIL top_moves: dec=%0d tap=%0d, expected 14/113", dec_cnt - dec_base, mtap);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit to, pb, found; int dc;
    mode = 0;
    do_start(1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (mtap == 8'd15) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || bus_if.EYE_MONITOR_CLEAR_FLAGS !== 1'b1) begin
      n_fail++; $display("FAIL midscan_reach_tap15: found=%b clear=%b, expected 1/1",
                         found, bus_if.EYE_MONITOR_CLEAR_FLAGS);
    end
    repeat (14) @(negedge clk);   // 8 settle cycles, then into SAMPLE
    #2 arst = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.DELAY_LINE_LOAD, bus_if.DELAY_LINE_MOVE, bus_if.DELAY_LINE_DIRECTION,
         bus_if.EYE_MONITOR_CLEAR_FLAGS, bus_if.BUSY, bus_if.DONE, bus_if.ERROR,
         bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH} !== 23'd0) begin
      n_fail++; $display("FAIL midscan_async_reset: busy=%b dir=%b done=%b, expected all 0",
                         bus_if.BUSY, bus_if.DELAY_LINE_DIRECTION, bus_if.DONE);
    end
    @(negedge clk);
    arst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_if.BUSY !== 1'b0 || bus_if.DELAY_LINE_LOAD !== 1'b0) begin
      n_fail++; $display("FAIL midscan_idle_after_reset: busy=%b load=%b, expected 0/0",
                         bus_if.BUSY, bus_if.DELAY_LINE_LOAD);
    end
    do_start(1);
    n_checks++;
    if (bus_if.DELAY_LINE_LOAD !== 1'b1) begin
      n_fail++; $display("FAIL midscan_reload: load=%b, expected 1", bus_if.DELAY_LINE_LOAD);
    end
    wait_done(5000, to, dc, pb);
    n_checks++;
    if (to || dc != 887 || bus_if.ERROR !== 1'b0 || bus_if.CENTER_TAP !== 8'd20 ||
        bus_if.WINDOW_WIDTH !== 8'd21 || dec_cnt - dec_base != 11) begin
      n_fail++; $display("FAIL midscan_rerun: timeout=%b cyc=%0d err=%b ctap=%0d width=%0d dec=%0d, expected 0/887/0/20/21/11",
                         to, dc, bus_if.ERROR, bus_if.CENTER_TAP, bus_if.WINDOW_WIDTH, dec_cnt - dec_base);
    end
  endtask

  initial begin
    bus_if.START = 1'b0;
    test_reset();
    test_centered_eye();
    test_no_eye();
    test_narrow_window();
    test_out_of_range();
    test_back_to_back();
    test_top_window();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
